// File: rtl/mem_access.sv
// MEM pipeline stage: performs loads/stores over a req/ack data bus with wait states,
// stalls upstream while an access is outstanding, and forms the write-back data.
module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        stallreq,
  output logic        mem_err
);

  localparam logic [7:0]  EXE_LB_OP    = 8'b1110_0000;
  localparam logic [7:0]  EXE_LBU_OP   = 8'b1110_0100;
  localparam logic [7:0]  EXE_LH_OP    = 8'b1110_0001;
  localparam logic [7:0]  EXE_LHU_OP   = 8'b1110_0101;
  localparam logic [7:0]  EXE_LW_OP    = 8'b1110_0011;
  localparam logic [7:0]  EXE_SB_OP    = 8'b1110_1000;
  localparam logic [7:0]  EXE_SH_OP    = 8'b1110_1001;
  localparam logic [7:0]  EXE_SW_OP    = 8'b1110_1011;
  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [7:0]  WAIT_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [7:0]  wait_cnt_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic        mem_err_r;
  logic        dbus_req_r;
  logic        dbus_we_r;
  logic [31:0] dbus_addr_r;
  logic [3:0]  dbus_sel_r;
  logic [31:0] dbus_wdata_r;
  logic        is_load_s;
  logic        is_store_s;
  logic        misalign_s;
  logic        timeout_s;

  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        case (a)
          2'b00:   s = 4'b1000;
          2'b01:   s = 4'b0100;
          2'b10:   s = 4'b0010;
          default: s = 4'b0001;
        endcase
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: s = a[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP, EXE_SW_OP:             s = 4'b1111;
      default:                          s = 4'b0000;
    endcase
    return s;
  endfunction

  // Big-endian lane pick followed by sign or zero extension
  function automatic logic [31:0] load_extract(input logic [7:0] op, input logic [1:0] a,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = rd[31:24];
      2'b01:   b = rd[23:16];
      2'b10:   b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = a[1] ? rd[15:0] : rd[31:16];
    case (op)
      EXE_LB_OP:  r = {{24{b[7]}}, b};
      EXE_LBU_OP: r = {24'h00_0000, b};
      EXE_LH_OP:  r = {{16{h[15]}}, h};
      EXE_LHU_OP: r = {16'h0000, h};
      default:    r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [7:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      EXE_SB_OP: r = {4{d[7:0]}};
      EXE_SH_OP: r = {2{d[15:0]}};
      default:   r = d;
    endcase
    return r;
  endfunction

  // Opcode decode and alignment check
  always_comb begin
    is_load_s  = aluop_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    is_store_s = aluop_i inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    case (aluop_i)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misalign_s = mem_addr_i[0];
      EXE_LW_OP, EXE_SW_OP:             misalign_s = (mem_addr_i[1:0] != 2'b00);
      default:                          misalign_s = 1'b0;
    endcase
    timeout_s = (wait_cnt_r == WAIT_LAST);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if ((is_load_s || is_store_s) && !misalign_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (dbus_ack || timeout_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Bus request launch, wait counting, read capture and timeout error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbus_req_r   <= 1'b0;
      dbus_we_r    <= 1'b0;
      dbus_addr_r  <= 32'h0000_0000;
      dbus_sel_r   <= 4'b0000;
      dbus_wdata_r <= 32'h0000_0000;
      wait_cnt_r   <= 8'd0;
      rdata_r      <= 32'h0000_0000;
      err_r        <= 1'b0;
      mem_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wait_cnt_r <= 8'd0;
          err_r      <= 1'b0;
          mem_err_r  <= 1'b0;
          if (state_nxt_s == BUSY) begin
            dbus_req_r   <= 1'b1;
            dbus_we_r    <= is_store_s;
            dbus_addr_r  <= {mem_addr_i[31:2], 2'b00};
            dbus_sel_r   <= lane_sel(aluop_i, mem_addr_i[1:0]);
            dbus_wdata_r <= store_lanes(aluop_i, reg2_i);
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            rdata_r    <= dbus_rdata;
            dbus_req_r <= 1'b0;
          end else if (timeout_s) begin
            dbus_req_r <= 1'b0;
            err_r      <= 1'b1;
            mem_err_r  <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        DONE: begin
          wait_cnt_r <= 8'd0;
          err_r      <= 1'b0;
          mem_err_r  <= 1'b0;
        end
        default: begin
          dbus_req_r <= 1'b0;
          wait_cnt_r <= 8'd0;
          err_r      <= 1'b0;
          mem_err_r  <= 1'b0;
        end
      endcase
    end
  end

  // Write-back outputs and stall; non-memory ops pass straight through
  always_comb begin
    mem_wd    = NOP_REG_ADDR;
    mem_wreg  = 1'b0;
    mem_wdata = ZERO_WORD;
    mem_hi    = ZERO_WORD;
    mem_lo    = ZERO_WORD;
    mem_whilo = 1'b0;
    stallreq  = 1'b0;
    mem_err   = 1'b0;
    if (!rst) begin
      stallreq = 1'b0;
    end else begin
      mem_wd    = wd_i;
      mem_wreg  = wreg_i;
      mem_wdata = wdata_i;
      mem_hi    = hi_i;
      mem_lo    = lo_i;
      mem_whilo = whilo_i;
      mem_err   = mem_err_r;
      case (state_r)
        IDLE: begin
          if (is_load_s || is_store_s) begin
            mem_wreg = 1'b0;
            if (misalign_s) begin
              mem_err = 1'b1;
            end else begin
              stallreq = 1'b1;
            end
          end else begin
            mem_wreg = wreg_i;
          end
        end
        BUSY: begin
          stallreq = 1'b1;
          mem_wreg = 1'b0;
        end
        DONE: begin
          if (is_load_s && !err_r) begin
            mem_wreg  = wreg_i;
            mem_wdata = load_extract(aluop_i, mem_addr_i[1:0], rdata_r);
          end else begin
            mem_wreg = 1'b0;
          end
        end
        default: begin
          mem_wreg = 1'b0;
        end
      endcase
    end
  end

  assign dbus_req   = dbus_req_r;
  assign dbus_we    = dbus_we_r;
  assign dbus_addr  = dbus_addr_r;
  assign dbus_sel   = dbus_sel_r;
  assign dbus_wdata = dbus_wdata_r;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized accesses checked
// against an arithmetic reference of the lane/extension/timing rules.
module tb_mem_access;

  localparam int TIMEOUT = 16;
  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;
  localparam logic [7:0] SW  = 8'b1110_1011;
  localparam logic [7:0] OR_OP = 8'b0010_0101;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, hi_i, lo_i;
  logic        whilo_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        mem_whilo;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        stallreq, mem_err;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_sel(dbus_sel),
    .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .stallreq(stallreq), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_byte(input logic [7:0] op);
    return op == LB || op == LBU || op == SB;
  endfunction
  function automatic bit ref_half(input logic [7:0] op);
    return op == LH || op == LHU || op == SH;
  endfunction
  function automatic bit ref_load(input logic [7:0] op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW;
  endfunction
  function automatic bit ref_store(input logic [7:0] op);
    return op == SB || op == SH || op == SW;
  endfunction
  function automatic bit ref_misaligned(input logic [7:0] op, input logic [31:0] a);
    if (ref_half(op)) return (a % 2) != 0;
    if (op == LW || op == SW) return (a % 4) != 0;
    return 1'b0;
  endfunction
  function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] a);
    if (ref_byte(op)) return 4'b1000 >> (a % 4);
    if (ref_half(op)) return 4'b1100 >> (2 * ((a % 4) / 2));
    return 4'b1111;
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] d);
    if (op == SB) return (d & 32'h0000_00FF) * 32'h0101_0101;
    if (op == SH) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    return d;
  endfunction
  function automatic logic [31:0] ref_loaddata(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] rd);
    logic [31:0] v;
    int sh;
    if (ref_byte(op)) begin
      sh = 8 * (3 - int'(a % 4));
      v = (rd >> sh) & 32'h0000_00FF;
      if (op == LB && v >= 32'd128) v = v - 32'd256;
    end else if (ref_half(op)) begin
      sh = 16 * (1 - int'((a % 4) / 2));
      v = (rd >> sh) & 32'h0000_FFFF;
      if (op == LH && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One instruction through the stage; ack_at = BUSY cycle index carrying ack (>= TIMEOUT: never)
  task automatic access(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata);
    bit ld, st, tmo, done;
    int stall_n, req_n;
    logic [31:0] hi, lo;
    logic whilo;
    hi = $urandom; lo = $urandom; whilo = 1'($urandom_range(0, 1));
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = wreg;
    wdata_i = wdata; hi_i = hi; lo_i = lo; whilo_i = whilo; dbus_ack = 1'b0;
    ld = ref_load(op); st = ref_store(op);
    @(negedge clk);
    check({nm, ":wd"}, 32'(mem_wd), 32'(wd));
    check({nm, ":hi"}, mem_hi, hi);
    check({nm, ":lo"}, mem_lo, lo);
    check({nm, ":whilo"}, 32'(mem_whilo), 32'(whilo));
    if (!ld && !st) begin
      check({nm, ":wdata"}, mem_wdata, wdata);
      check({nm, ":wreg"}, 32'(mem_wreg), 32'(wreg));
      check({nm, ":stall"}, 32'(stallreq), 32'd0);
      check({nm, ":err"}, 32'(mem_err), 32'd0);
      check({nm, ":req"}, 32'(dbus_req), 32'd0);
      @(posedge clk); #1;
    end else if (ref_misaligned(op, addr)) begin
      check({nm, ":mis_err"}, 32'(mem_err), 32'd1);
      check({nm, ":mis_wreg"}, 32'(mem_wreg), 32'd0);
      check({nm, ":mis_stall"}, 32'(stallreq), 32'd0);
      check({nm, ":mis_wdata"}, mem_wdata, wdata);
      @(posedge clk); #1;
      check({nm, ":mis_req"}, 32'(dbus_req), 32'd0);
    end else begin
      check({nm, ":idle_stall"}, 32'(stallreq), 32'd1);
      check({nm, ":idle_req"}, 32'(dbus_req), 32'd0);
      check({nm, ":idle_wreg"}, 32'(mem_wreg), 32'd0);
      tmo = (ack_at >= TIMEOUT);
      stall_n = 1; req_n = 0; done = 1'b0;
      for (int k = 0; k < TIMEOUT + 4 && !done; k++) begin
        @(posedge clk); #1;
        dbus_ack = (k == ack_at);
        dbus_rdata = (k == ack_at) ? rdata : $urandom;
        @(negedge clk);
        if (stallreq) begin
          stall_n++;
          if (dbus_req) req_n++;
          check({nm, ":busy_wreg"}, 32'(mem_wreg), 32'd0);
          check({nm, ":addr"}, dbus_addr, addr & 32'hFFFF_FFFC);
          check({nm, ":sel"}, 32'(dbus_sel), 32'(ref_sel(op, addr)));
          if (k == 0) begin
            check({nm, ":we"}, 32'(dbus_we), 32'(st));
            if (st) check({nm, ":bus_wdata"}, dbus_wdata, ref_wdata(op, reg2));
          end
        end else begin
          done = 1'b1;
          check({nm, ":done_req"}, 32'(dbus_req), 32'd0);
          check({nm, ":done_err"}, 32'(mem_err), 32'(tmo));
          check({nm, ":done_wreg"}, 32'(mem_wreg), 32'((ld && !tmo) ? wreg : 1'b0));
          check({nm, ":done_wd"}, 32'(mem_wd), 32'(wd));
          if (ld && !tmo) check({nm, ":load_data"}, mem_wdata, ref_loaddata(op, addr, rdata));
        end
      end
      check({nm, ":completed"}, 32'(done), 32'd1);
      check({nm, ":stall_cycles"}, 32'(stall_n), tmo ? 32'(TIMEOUT + 1) : 32'(ack_at + 2));
      check({nm, ":req_cycles"}, 32'(req_n), tmo ? 32'(TIMEOUT) : 32'(ack_at + 1));
      @(posedge clk); #1;
      dbus_ack = 1'b0;
    end
  endtask

  initial begin
    logic [7:0]  op;
    logic [31:0] addr;
    int          sel, ack_at;
    logic [7:0]  mem_ops [8];
    mem_ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};

    rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF; hi_i = 32'h1; lo_i = 32'h2;
    whilo_i = 1'b1; aluop_i = LW; mem_addr_i = 32'h100; reg2_i = 32'h0;
    #7;
    check("rst:wd", 32'(mem_wd), 32'd0);
    check("rst:wreg", 32'(mem_wreg), 32'd0);
    check("rst:wdata", mem_wdata, 32'd0);
    check("rst:hi", mem_hi, 32'd0);
    check("rst:whilo", 32'(mem_whilo), 32'd0);
    check("rst:stall", 32'(stallreq), 32'd0);
    check("rst:req", 32'(dbus_req), 32'd0);
    check("rst:err", 32'(mem_err), 32'd0);
    aluop_i = OR_OP;
    #5 rst = 1'b1;
    @(posedge clk); #1;

    access("nonmem", OR_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 32'h0);
    access("lb", LB, 32'h101, 32'h0, 5'd3, 1'b1, 32'h0, 2, 32'h11F0_3344);
    check("lb_direct", ref_loaddata(LB, 32'h101, 32'h11F0_3344), 32'hFFFF_FFF0);
    access("lbu", LBU, 32'h101, 32'h0, 5'd3, 1'b1, 32'h0, 2, 32'h11F0_3344);
    access("sh", SH, 32'h202, 32'hAAAA_BEEF, 5'd4, 1'b1, 32'h77, 0, 32'h0);
    access("lw_mis", LW, 32'h103, 32'h0, 5'd6, 1'b1, 32'h55, 0, 32'h0);
    access("lw_tmo", LW, 32'h100, 32'h0, 5'd7, 1'b1, 32'h66, 255, 32'h0);
    access("after_tmo", OR_OP, 32'h0, 32'h0, 5'd8, 1'b1, 32'hCAFE, 0, 32'h0);

    // Reset in the middle of a BUSY access
    aluop_i = LW; mem_addr_i = 32'h400; wreg_i = 1'b1; wd_i = 5'd10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("midrst:req_before", 32'(dbus_req), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst:req", 32'(dbus_req), 32'd0);
    check("midrst:stall", 32'(stallreq), 32'd0);
    check("midrst:wd", 32'(mem_wd), 32'd0);
    @(negedge clk);
    aluop_i = OR_OP; wd_i = 5'd11; wdata_i = 32'h0BAD_F00D;
    rst = 1'b1;
    @(posedge clk); #1;
    dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("stray:stall", 32'(stallreq), 32'd0);
    check("stray:req", 32'(dbus_req), 32'd0);
    check("stray:wdata", mem_wdata, 32'h0BAD_F00D);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    check("stray:req2", 32'(dbus_req), 32'd0);
    check("stray:err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
    access("post_rst_lhu", LHU, 32'h502, 32'h0, 5'd12, 1'b1, 32'h0, 1, 32'h1234_89AB);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 8);
      if (sel < 8) begin
        op = mem_ops[sel];
      end else begin
        op = 8'($urandom_range(0, 255));
        if (ref_load(op) || ref_store(op)) op = OR_OP;
      end
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (ref_half(op)) addr[0] = 1'b0;
        if (op == LW || op == SW) addr[1:0] = 2'b00;
      end
      ack_at = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 5));
      access("rand", op, addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom, ack_at, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
